rxtx_fifo_buffer: RTL

- Single-clock, parametrised successor to the rx/tx dual-RAM buffer memory.
- Holds one receive FIFO and one transmit FIFO. Each has independent push/pop handshakes, occupancy counts, full/empty flags and sticky error flags.
- Address management moves inside the block, so upstream UART/upgrade logic no longer generates RAM addresses.
- Sits between the serial link engine and the flash-upgrade controller.

---
 rtl/rxtx_buf_pkg.sv | 22 ++
 rtl/sync_fifo_channel.sv | 113 +++++++++++
 rtl/rxtx_fifo_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rxtx_buf_pkg.sv
// Shared constants and helpers for the rx/tx FIFO buffer.
// Optional almost-full/almost-empty flags are enabled with FIFO_ALMOST_FLAGS_EN.
package rxtx_buf_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;

  // Bit positions inside err_ovf / err_unf.
  localparam int ERR_RX = 0;
  localparam int ERR_TX = 1;

  // Ceiling log2, used to size pointers from DEPTH.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_channel.sv
// One single-clock FIFO channel: RAM, pointers, occupancy, flags and error pulses.
// FIFO_ALMOST_FLAGS_EN adds registered afull/aempty outputs.
module sync_fifo_channel
  import rxtx_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
`ifdef FIFO_ALMOST_FLAGS_EN
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
`endif
  localparam int AW        = clogb2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  afull,
  output logic                  aempty,
`endif
  output logic                  ovf_evt,
  output logic                  unf_evt
);

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic [AW:0]           count_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      rd_en   = pop && !empty;
      // At full, a coincident pop frees a slot so the push is accepted.
      wr_en   = push && (!full || rd_en);
      ovf_evt = push && !wr_en;
      unf_evt = pop && !rd_en;
      case ({wr_en, rd_en})
        2'b10:   count_nxt = count + CNT_ONE;
        2'b01:   count_nxt = count - CNT_ONE;
        default: count_nxt = count;
      endcase
    end
  end

  // NOTE: RAM contents carry no reset, so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking reads see the old word when push and pop hit the same address at full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CNT_MAX);
      empty <= (count_nxt == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_en;
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          rdata  <= mem[rd_ptr];
        end
      end
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      afull  <= (count_nxt >= (AW+1)'(AF_LEVEL));
      aempty <= (count_nxt <= (AW+1)'(AE_LEVEL));
    end
  end
`endif

endmodule

// File: rtl/rxtx_fifo_buffer.sv
// Receive and transmit FIFO pair with sticky overflow/underflow flags.
// FIFO_ALMOST_FLAGS_EN adds rx/tx almost-full and almost-empty outputs.
module rxtx_fifo_buffer
  import rxtx_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
`ifdef FIFO_ALMOST_FLAGS_EN
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
`endif
  localparam int AW        = clogb2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rx_push,
  input  logic [DATA_WIDTH-1:0] rx_wdata,
  input  logic                  rx_pop,
  output logic [DATA_WIDTH-1:0] rx_rdata,
  output logic                  rx_rvalid,
  output logic                  rx_full,
  output logic                  rx_empty,
  output logic [AW:0]           rx_count,
  input  logic                  rx_flush,
  input  logic                  tx_push,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_pop,
  output logic [DATA_WIDTH-1:0] tx_rdata,
  output logic                  tx_rvalid,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic [AW:0]           tx_count,
  input  logic                  tx_flush,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  rx_afull,
  output logic                  rx_aempty,
  output logic                  tx_afull,
  output logic                  tx_aempty,
`endif
  output logic [1:0]            err_ovf,
  output logic [1:0]            err_unf,
  input  logic                  err_clr
);

  logic       rx_ovf, rx_unf, tx_ovf, tx_unf;
  logic [1:0] ovf_set, unf_set;

  sync_fifo_channel #(
    .DATA_WIDTH (DATA_WIDTH),
`ifdef FIFO_ALMOST_FLAGS_EN
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL),
`endif
    .DEPTH      (DEPTH)
  ) u_rx (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .wdata   (rx_wdata),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .rdata   (rx_rdata),
    .rvalid  (rx_rvalid),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count),
`ifdef FIFO_ALMOST_FLAGS_EN
    .afull   (rx_afull),
    .aempty  (rx_aempty),
`endif
    .ovf_evt (rx_ovf),
    .unf_evt (rx_unf)
  );

  sync_fifo_channel #(
    .DATA_WIDTH (DATA_WIDTH),
`ifdef FIFO_ALMOST_FLAGS_EN
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL),
`endif
    .DEPTH      (DEPTH)
  ) u_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (tx_push),
    .wdata   (tx_wdata),
    .pop     (tx_pop),
    .flush   (tx_flush),
    .rdata   (tx_rdata),
    .rvalid  (tx_rvalid),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count),
`ifdef FIFO_ALMOST_FLAGS_EN
    .afull   (tx_afull),
    .aempty  (tx_aempty),
`endif
    .ovf_evt (tx_ovf),
    .unf_evt (tx_unf)
  );

  always_comb begin
    ovf_set         = '0;
    unf_set         = '0;
    ovf_set[ERR_RX] = rx_ovf;
    ovf_set[ERR_TX] = tx_ovf;
    unf_set[ERR_RX] = rx_unf;
    unf_set[ERR_TX] = tx_unf;
  end

  // A new error event in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf <= '0;
      err_unf <= '0;
    end else begin
      err_ovf <= (err_clr ? 2'b00 : err_ovf) | ovf_set;
      err_unf <= (err_clr ? 2'b00 : err_unf) | unf_set;
    end
  end

endmodule
